// File: rtl/hash_ser_pkg.sv
// Shared types and defaults for the hash word serializer.
// Holds the FSM state encoding and the default strobe/timeout lengths.
package hash_ser_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StLo,
      StHi
   } state_e;

   localparam int unsigned DefHalfPeriod = 2097152;
   localparam int unsigned DefTimeout    = 10000000;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/hash_word_serializer_if.sv
// Hash input, start/ack controls and word-strobe outputs of the serializer.
// The master side feeds the hash and acknowledges; the slave side is the serializer.
interface hash_word_serializer_if #(
   parameter int unsigned HASH_W = 256,
   parameter int unsigned OUT_W  = 8
);
   logic [HASH_W-1:0] hash;
   logic              out_en;
   logic              ack_rpi0;
   logic [OUT_W-1:0]  part_hash;
   logic              load_rpi0;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output hash, out_en, ack_rpi0,
      input  part_hash, load_rpi0, busy, done, err
   );

   modport slave (
      input  hash, out_en, ack_rpi0,
      output part_hash, load_rpi0, busy, done, err
   );
endinterface

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with asynchronous active-high reset to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst_p,
   input  logic d,
   output logic q
);
   logic s1_q, s2_q;

   always_ff @(posedge clk or posedge rst_p) begin
      if (rst_p) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= d;
         s2_q <= s1_q;
      end
   end

   assign q = s2_q;
endmodule

// File: rtl/hash_word_serializer.sv
// Captures a finished hash and presents it one OUT_W word at a time with a load strobe,
// either on a fixed half-period timer or paced by an acknowledge from the receiver.
module hash_word_serializer
   import hash_ser_pkg::*;
#(
   parameter int unsigned HASH_W      = 256,
   parameter int unsigned OUT_W       = 8,
   parameter bit          MSB_FIRST   = 1'b1,
   parameter int unsigned HALF_PERIOD = DefHalfPeriod,
   parameter bit          USE_ACK     = 1'b0,
   parameter int unsigned TIMEOUT     = DefTimeout
) (
   input logic                   clk,
   input logic                   rst_p,
   hash_word_serializer_if.slave bus
);
   localparam int unsigned NWords   = HASH_W / OUT_W;
   localparam int unsigned CntW     = (NWords > 1) ? $clog2(NWords) : 1;
   localparam int unsigned TimerMax = max_u(HALF_PERIOD, TIMEOUT);
   localparam int unsigned TimerW   = $clog2(TimerMax + 1);

   localparam logic [CntW-1:0]   LastWord = CntW'(NWords - 1);
   localparam logic [TimerW-1:0] HpLast   = TimerW'(HALF_PERIOD - 1);
   localparam logic [TimerW-1:0] ToLast   = TimerW'(TIMEOUT - 1);

   state_e             state_q, state_d;
   logic [HASH_W-1:0]  shreg_q, shreg_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [TimerW-1:0]  timer_q, timer_d;
   logic               load_q, load_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic               ack_s;
   logic               hi_end;

   sync_2ff u_ack_sync (
      .clk  (clk),
      .rst_p(rst_p),
      .d    (bus.ack_rpi0),
      .q    (ack_s)
   );

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      timer_d = timer_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      hi_end  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.out_en) begin
               shreg_d = bus.hash;
               cnt_d   = '0;
               timer_d = '0;
               state_d = StLo;
            end
         end
         StLo: begin
            // Saturate so an ack held high can stall LO indefinitely.
            if (timer_q != HpLast) timer_d = timer_q + TimerW'(1);
            if (timer_q == HpLast && (!USE_ACK || !ack_s)) begin
               timer_d = '0;
               state_d = StHi;
            end
         end
         StHi: begin
            timer_d = timer_q + TimerW'(1);
            hi_end  = USE_ACK ? ack_s : (timer_q == HpLast);
            if (hi_end) begin
               timer_d = '0;
               if (cnt_q == LastWord) begin
                  done_d  = 1'b1;
                  shreg_d = '0;
                  state_d = StIdle;
               end else begin
                  shreg_d = MSB_FIRST ? (shreg_q << OUT_W) : (shreg_q >> OUT_W);
                  cnt_d   = cnt_q + CntW'(1);
                  state_d = StLo;
               end
            end else if (USE_ACK && timer_q == ToLast) begin
               err_d   = 1'b1;
               shreg_d = '0;
               timer_d = '0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      load_d = (state_d == StHi);
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or posedge rst_p) begin
      if (rst_p) begin
         state_q <= StIdle;
         shreg_q <= '0;
         cnt_q   <= '0;
         timer_q <= '0;
         load_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         timer_q <= timer_d;
         load_q  <= load_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign bus.part_hash = MSB_FIRST ? shreg_q[HASH_W-1 -: OUT_W] : shreg_q[OUT_W-1:0];
   assign bus.load_rpi0 = load_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_hash_word_serializer.sv
// Scoreboard bench: timed MSB/LSB-first, back-to-back, ack handshake, timeout, async reset.
module tb_hash_word_serializer;
   logic clk = 1'b0;
   logic rst_p = 1'b1;
   always #5 clk = ~clk;

   hash_word_serializer_if #(.HASH_W(32), .OUT_W(8)) ifm ();
   hash_word_serializer_if #(.HASH_W(32), .OUT_W(8)) ifl ();
   hash_word_serializer_if #(.HASH_W(32), .OUT_W(8)) ifa ();

   hash_word_serializer #(.HASH_W(32), .OUT_W(8), .MSB_FIRST(1'b1), .HALF_PERIOD(4),
                          .USE_ACK(1'b0), .TIMEOUT(20))
      u_msb (.clk(clk), .rst_p(rst_p), .bus(ifm));
   hash_word_serializer #(.HASH_W(32), .OUT_W(8), .MSB_FIRST(1'b0), .HALF_PERIOD(4),
                          .USE_ACK(1'b0), .TIMEOUT(20))
      u_lsb (.clk(clk), .rst_p(rst_p), .bus(ifl));
   hash_word_serializer #(.HASH_W(32), .OUT_W(8), .MSB_FIRST(1'b1), .HALF_PERIOD(4),
                          .USE_ACK(1'b1), .TIMEOUT(20))
      u_ack (.clk(clk), .rst_p(rst_p), .bus(ifa));

   int total = 0;
   int bad = 0;
   logic [7:0] exp_q[$];
   logic sel_lsb = 1'b0;

   wire [7:0] o_part = sel_lsb ? ifl.part_hash : ifm.part_hash;
   wire       o_load = sel_lsb ? ifl.load_rpi0 : ifm.load_rpi0;
   wire       o_busy = sel_lsb ? ifl.busy : ifm.busy;
   wire       o_done = sel_lsb ? ifl.done : ifm.done;

   task automatic push_words(input logic [31:0] h, input bit lsb);
      for (int i = 0; i < 4; i++) exp_q.push_back(lsb ? h[8*i +: 8] : h[31-8*i -: 8]);
   endtask

   task automatic set_hash(input logic [31:0] h);
      if (sel_lsb) ifl.hash = h; else ifm.hash = h;
   endtask

   task automatic set_out_en(input logic v);
      if (sel_lsb) ifl.out_en = v; else ifm.out_en = v;
   endtask

   // Observes one timed transaction, started at the previous edge, through its done cycle.
   task automatic monitor_timed(input bit hold, input bit change, input logic [31:0] mid);
      logic [7:0] e;
      int ph;
      for (int c = 1; c <= 33; c++) begin
         @(negedge clk);
         if (c <= 32) begin
            ph = (c - 1) % 8;
            total++;
            if (o_load !== (ph >= 4)) begin
               bad++; $display("FAIL load c=%0d got=%0b want=%0b", c, o_load, (ph >= 4));
            end
            total++;
            if (o_busy !== 1'b1) begin bad++; $display("FAIL busy c=%0d got=%0b want=1", c, o_busy); end
            total++;
            if (o_done !== 1'b0) begin bad++; $display("FAIL done_early c=%0d got=%0b want=0", c, o_done); end
            if (ph == 0 && exp_q.size() > 0) begin
               total++;
               if (o_part !== exp_q[0]) begin
                  bad++; $display("FAIL word_lo c=%0d got=%0h want=%0h", c, o_part, exp_q[0]);
               end
            end
            if (ph == 4) begin
               total++;
               if (exp_q.size() == 0) begin
                  bad++; $display("FAIL word_hi c=%0d got=%0h want=<none>", c, o_part);
               end else begin
                  e = exp_q.pop_front();
                  if (o_part !== e) begin
                     bad++; $display("FAIL word_hi c=%0d got=%0h want=%0h", c, o_part, e);
                  end
               end
            end
         end else begin
            total++;
            if ({o_done, o_busy, o_load, o_part} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
               bad++;
               $display("FAIL end done/busy/load/part got=%0b%0b%0b/%0h want=100/0",
                        o_done, o_busy, o_load, o_part);
            end
         end
         if (c == 1 && !hold) set_out_en(1'b0);
         if (c == 12 && change) set_hash(mid);
      end
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL leftover got=%0d want=0", exp_q.size()); end
   endtask

   task automatic test_reset();
      #1;
      total++;
      if ({ifm.busy, ifm.load_rpi0, ifm.done, ifm.err, ifm.part_hash} !== 12'h0) begin
         bad++; $display("FAIL reset_msb got=%0h want=0", {ifm.busy, ifm.load_rpi0, ifm.part_hash});
      end
      total++;
      if ({ifl.busy, ifl.load_rpi0, ifl.done, ifl.err, ifl.part_hash} !== 12'h0) begin
         bad++; $display("FAIL reset_lsb got=%0h want=0", {ifl.busy, ifl.load_rpi0, ifl.part_hash});
      end
      @(negedge clk);
      rst_p = 1'b0;
      @(negedge clk);
      total++;
      if ({ifa.busy, ifa.load_rpi0, ifa.done, ifa.err, ifa.part_hash} !== 12'h0) begin
         bad++; $display("FAIL reset_ack got=%0h want=0", {ifa.busy, ifa.load_rpi0, ifa.part_hash});
      end
   endtask

   task automatic test_timed_msb();
      sel_lsb = 1'b0;
      push_words(32'hDEADBEEF, 1'b0);
      set_hash(32'hDEADBEEF);
      set_out_en(1'b1);
      monitor_timed(1'b0, 1'b0, 32'h0);
   endtask

   task automatic test_timed_lsb();
      sel_lsb = 1'b1;
      push_words(32'hDEADBEEF, 1'b1);
      set_hash(32'hDEADBEEF);
      set_out_en(1'b1);
      monitor_timed(1'b0, 1'b0, 32'h0);
      sel_lsb = 1'b0;
   endtask

   task automatic test_back_to_back();
      sel_lsb = 1'b0;
      @(negedge clk);
      push_words(32'hDEADBEEF, 1'b0);
      set_hash(32'hDEADBEEF);
      set_out_en(1'b1);
      monitor_timed(1'b1, 1'b1, 32'h12345678);
      push_words(32'h12345678, 1'b0);
      monitor_timed(1'b0, 1'b0, 32'h0);
   endtask

   task automatic wait_ack_load(input logic v, input string name);
      int n = 0;
      while (ifa.load_rpi0 !== v && n < 40) begin @(negedge clk); n++; end
      total++;
      if (ifa.load_rpi0 !== v) begin bad++; $display("FAIL %s got=%0b want=%0b", name, ifa.load_rpi0, v); end
   endtask

   task automatic check_ack_word(input string name);
      logic [7:0] e;
      total++;
      if (exp_q.size() == 0) begin
         bad++; $display("FAIL %s got=%0h want=<none>", name, ifa.part_hash);
      end else begin
         e = exp_q.pop_front();
         if (ifa.part_hash !== e) begin bad++; $display("FAIL %s got=%0h want=%0h", name, ifa.part_hash, e); end
      end
   endtask

   task automatic test_ack();
      int n;
      exp_q.delete();
      ifa.ack_rpi0 = 1'b0;
      @(negedge clk);
      push_words(32'hA1B2C3D4, 1'b0);
      ifa.hash = 32'hA1B2C3D4;
      ifa.out_en = 1'b1;
      @(negedge clk);
      ifa.out_en = 1'b0;
      wait_ack_load(1'b1, "ack_hi1");
      check_ack_word("ack_word1");
      repeat (10) @(negedge clk);
      ifa.ack_rpi0 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      total++;
      if (ifa.load_rpi0 !== 1'b1) begin bad++; $display("FAIL ack_lat2 got=%0b want=1", ifa.load_rpi0); end
      @(negedge clk);
      total++;
      if (ifa.load_rpi0 !== 1'b0) begin bad++; $display("FAIL ack_lat3 got=%0b want=0", ifa.load_rpi0); end
      total++;
      if (ifa.part_hash !== 8'hB2) begin bad++; $display("FAIL ack_next got=%0h want=b2", ifa.part_hash); end
      repeat (10) @(negedge clk);
      total++;
      if ({ifa.load_rpi0, ifa.busy} !== 2'b01) begin
         bad++; $display("FAIL ack_stall load/busy got=%0b%0b want=01", ifa.load_rpi0, ifa.busy);
      end
      ifa.ack_rpi0 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      total++;
      if (ifa.load_rpi0 !== 1'b0) begin bad++; $display("FAIL ack_release2 got=%0b want=0", ifa.load_rpi0); end
      @(negedge clk);
      total++;
      if (ifa.load_rpi0 !== 1'b1) begin bad++; $display("FAIL ack_release3 got=%0b want=1", ifa.load_rpi0); end
      check_ack_word("ack_word2");
      for (int i = 0; i < 2; i++) begin
         ifa.ack_rpi0 = 1'b1;
         wait_ack_load(1'b0, "ack_lo_loop");
         ifa.ack_rpi0 = 1'b0;
         wait_ack_load(1'b1, "ack_hi_loop");
         check_ack_word("ack_word_loop");
      end
      ifa.ack_rpi0 = 1'b1;
      n = 0;
      while (ifa.done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      total++;
      if ({ifa.done, ifa.busy, ifa.load_rpi0} !== 3'b100) begin
         bad++; $display("FAIL ack_done done/busy/load got=%0b%0b%0b want=100", ifa.done, ifa.busy, ifa.load_rpi0);
      end
      ifa.ack_rpi0 = 1'b0;
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL ack_leftover got=%0d want=0", exp_q.size()); end
   endtask

   task automatic test_timeout();
      exp_q.delete();
      ifa.ack_rpi0 = 1'b0;
      @(negedge clk);
      exp_q.push_back(8'h5A);
      ifa.hash = 32'h5A6B7C8D;
      ifa.out_en = 1'b1;
      @(negedge clk);
      ifa.out_en = 1'b0;
      wait_ack_load(1'b1, "to_hi");
      check_ack_word("to_word");
      repeat (19) @(negedge clk);
      total++;
      if ({ifa.err, ifa.load_rpi0} !== 2'b01) begin
         bad++; $display("FAIL to_early err/load got=%0b%0b want=01", ifa.err, ifa.load_rpi0);
      end
      @(negedge clk);
      total++;
      if ({ifa.err, ifa.busy, ifa.load_rpi0, ifa.part_hash} !== {3'b100, 8'h00}) begin
         bad++; $display("FAIL to_err err/busy/load/part got=%0b%0b%0b/%0h want=100/0",
                         ifa.err, ifa.busy, ifa.load_rpi0, ifa.part_hash);
      end
      @(negedge clk);
      total++;
      if ({ifa.err, ifa.busy} !== 2'b00) begin
         bad++; $display("FAIL to_after err/busy got=%0b%0b want=00", ifa.err, ifa.busy);
      end
   endtask

   task automatic test_async_reset();
      sel_lsb = 1'b0;
      exp_q.delete();
      @(negedge clk);
      set_hash(32'hDEADBEEF);
      set_out_en(1'b1);
      @(negedge clk);
      set_out_en(1'b0);
      repeat (17) @(negedge clk);
      total++;
      if (ifm.part_hash !== 8'hBE) begin bad++; $display("FAIL rst_pre got=%0h want=be", ifm.part_hash); end
      #2 rst_p = 1'b1;
      #1;
      total++;
      if ({ifm.busy, ifm.load_rpi0, ifm.done, ifm.err, ifm.part_hash} !== 12'h0) begin
         bad++; $display("FAIL rst_async busy/load/part got=%0b%0b/%0h want=00/0",
                         ifm.busy, ifm.load_rpi0, ifm.part_hash);
      end
      @(negedge clk);
      #2 rst_p = 1'b0;
      @(negedge clk);
      push_words(32'h01020304, 1'b0);
      set_hash(32'h01020304);
      set_out_en(1'b1);
      monitor_timed(1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      ifm.hash = '0; ifm.out_en = 1'b0; ifm.ack_rpi0 = 1'b0;
      ifl.hash = '0; ifl.out_en = 1'b0; ifl.ack_rpi0 = 1'b0;
      ifa.hash = '0; ifa.out_en = 1'b0; ifa.ack_rpi0 = 1'b0;
      test_reset();
      test_timed_msb();
      test_timed_lsb();
      test_back_to_back();
      test_ack();
      test_timeout();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
